alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the 4-bit combinational ALU.
- Captures Y, carry and overflow with a valid/ready handshake, and derives zero and negative flags.
- Keeps a sticky overflow flag and a delivered-result counter.
- A 2-entry skid buffer lets in_ready be a registered signal, so the ALU is never stalled combinationally by the consumer.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_result_stage_if.sv | 69 ++++++
 rtl/alu_skid_buf.sv | 89 ++++++++
 rtl/alu_result_stage.sv | 107 ++++++++++
 tb/tb_alu_result_stage.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU result stage and its skid buffer.
//   - Opcode encodings of the upstream 4-bit ALU (OP_ADD .. OP_SHR; 1011 and above are illegal).
//   - Stage state encoding (ST_EMPTY / ST_ONE / ST_FULL).
//   - is_arith(): true for the opcodes whose carry/overflow outputs are meaningful.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XNOR = 4'b1000;
    localparam logic [3:0] OP_SHL  = 4'b1001;
    localparam logic [3:0] OP_SHR  = 4'b1010;

    // First illegal opcode; the ALU drives Y=0 for everything from here up.
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    function automatic logic is_arith(input logic [3:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: handshake and data bundle between the ALU, the result stage and the
// consumer.
//   Producer side : in_valid, in_ready, in_y, in_sel, in_carry, in_overflow
//   Consumer side : out_valid, out_ready, out_y, out_carry, out_overflow, out_zero, out_neg
//                   (+ out_parity when ALU_RESULT_PARITY_EN is defined)
// Modports:
//   master - the environment around the stage (drives in_* and out_ready)
//   slave  - the result stage itself
interface alu_result_stage_if #(
    parameter int unsigned width = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] in_y;
    logic [3:0]       in_sel;
    logic             in_carry;
    logic             in_overflow;

    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] out_y;
    logic             out_carry;
    logic             out_overflow;
    logic             out_zero;
    logic             out_neg;
`ifdef ALU_RESULT_PARITY_EN
    logic             out_parity;
`endif

    modport master (
        output in_valid,
        output in_y,
        output in_sel,
        output in_carry,
        output in_overflow,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_y,
        input  out_carry,
        input  out_overflow,
        input  out_zero,
`ifdef ALU_RESULT_PARITY_EN
        input  out_parity,
`endif
        input  out_neg
    );

    modport slave (
        input  in_valid,
        input  in_y,
        input  in_sel,
        input  in_carry,
        input  in_overflow,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_y,
        output out_carry,
        output out_overflow,
        output out_zero,
`ifdef ALU_RESULT_PARITY_EN
        output out_parity,
`endif
        output out_neg
    );

endinterface

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: generic 2-entry skid buffer with a registered in_ready.
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_ready   - upstream handshake; in_ready comes straight from a flop
//   in_data             - upstream payload (dw bits)
//   out_valid/out_ready - downstream handshake
//   out_data            - downstream payload, always the main entry
// The main entry feeds the output; the skid entry absorbs the one word that can arrive in
// the cycle the consumer stalls, because in_ready cannot react combinationally.
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter int unsigned dw = 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [dw-1:0] in_data,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [dw-1:0] out_data
);

    stage_state_e  state_q, state_d;
    logic [dw-1:0] main_q, main_d;
    logic [dw-1:0] skid_q, skid_d;
    logic          in_ready_q;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain path can fire.
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // Registered, but looks one state ahead so no word is ever dropped.
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the 4-bit combinational ALU.
//   clk, rst_n  - clock, synchronous active-low reset
//   bus         - alu_result_stage_if.slave: ALU result in (valid/ready), flagged result out
//   clr_sticky  - clears sticky_ovf (an overflow capture in the same cycle wins)
//   sticky_ovf  - set by any accepted word whose masked overflow is 1
//   result_cnt  - number of results delivered downstream, wraps modulo 2^cnt_w
// Flags (zero, neg, masked carry/overflow) are derived at capture and stored with the word,
// so the output side is pure flops. Carry/overflow only survive for ADD and SUB.
// Optional macro ALU_RESULT_PARITY_EN adds bus.out_parity = ^out_y, stored in both entries.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned width = 4,
    parameter int unsigned cnt_w = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_stage_if.slave bus,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [cnt_w-1:0] result_cnt
);

    // Payload layout, LSB first: neg, zero, overflow, carry, y[width-1:0] (, parity).
`ifdef ALU_RESULT_PARITY_EN
    localparam int unsigned pw = width + 5;
`else
    localparam int unsigned pw = width + 4;
`endif

    logic          carry_m;
    logic          ovf_m;
    logic          zero_c;
    logic          neg_c;
    logic [pw-1:0] cap_data;
    logic [pw-1:0] held_data;
    logic          in_xfer;
    logic          out_xfer;

    logic             sticky_q, sticky_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;

    // Capture-side flag derivation.
    assign carry_m = is_arith(bus.in_sel) && bus.in_carry;
    assign ovf_m   = is_arith(bus.in_sel) && bus.in_overflow;
    assign zero_c  = (bus.in_y == '0);
    assign neg_c   = bus.in_y[width-1];

`ifdef ALU_RESULT_PARITY_EN
    assign cap_data = {^bus.in_y, bus.in_y, carry_m, ovf_m, zero_c, neg_c};
`else
    assign cap_data = {bus.in_y, carry_m, ovf_m, zero_c, neg_c};
`endif

    alu_skid_buf #(
        .dw(pw)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .in_data  (cap_data),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready),
        .out_data (held_data)
    );

    assign bus.out_neg      = held_data[0];
    assign bus.out_zero     = held_data[1];
    assign bus.out_overflow = held_data[2];
    assign bus.out_carry    = held_data[3];
    assign bus.out_y        = held_data[width+3:4];
`ifdef ALU_RESULT_PARITY_EN
    assign bus.out_parity   = held_data[width+4];
`endif

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;

    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        // Set has priority over clear so a same-cycle overflow is never lost.
        if (in_xfer && ovf_m) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (out_xfer) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sticky_ovf = sticky_q;
    assign result_cnt = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed scenarios plus a randomized run for alu_result_stage, checked
// against a queue-based reference model (queue depth 2 = stage capacity).
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int unsigned width = 4;
    localparam int unsigned cnt_w = 2;

    typedef struct packed {
        logic [width-1:0] y;
        logic             c;
        logic             o;
        logic             z;
        logic             n;
        logic             p;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr_sticky;
    logic             sticky_ovf;
    logic [cnt_w-1:0] result_cnt;

    alu_result_stage_if #(.width(width)) bus ();

    alu_result_stage #(
        .width(width),
        .cnt_w(cnt_w)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_sticky(clr_sticky),
        .sticky_ovf(sticky_ovf),
        .result_cnt(result_cnt)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic sticky_m;
    int   cnt_m;

    function automatic exp_t expect_word(input logic [width-1:0] y, input logic [3:0] sel,
                                         input logic c, input logic o);
        exp_t e;
        logic arith;
        arith = (sel == 4'b0000) || (sel == 4'b0001);
        e.y = y;
        e.c = arith ? c : 1'b0;
        e.o = arith ? o : 1'b0;
        e.z = (y == 0);
        e.n = y[width-1];
        e.p = ^y;
        return e;
    endfunction

    // Applies one cycle of stimulus, advances the model, and returns 1 ns after the edge.
    task automatic drive_cycle(input logic v, input logic [width-1:0] y, input logic [3:0] sel,
                               input logic c, input logic o, input logic ordy, input logic clr);
        exp_t e;
        exp_t dummy;
        logic in_x;
        logic out_x;
        bus.in_valid    = v;
        bus.in_y        = y;
        bus.in_sel      = sel;
        bus.in_carry    = c;
        bus.in_overflow = o;
        bus.out_ready   = ordy;
        clr_sticky      = clr;
        in_x  = v && (exp_q.size() < 2);
        out_x = ordy && (exp_q.size() != 0);
        e = expect_word(y, sel, c, o);
        if (out_x) begin
            dummy = exp_q.pop_front();
            cnt_m = (cnt_m + 1) % (1 << cnt_w);
        end
        if (in_x) exp_q.push_back(e);
        if (in_x && e.o) sticky_m = 1'b1;
        else if (clr) sticky_m = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_y        = '0;
        bus.in_sel      = OP_ADD;
        bus.in_carry    = 1'b0;
        bus.in_overflow = 1'b0;
        bus.out_ready   = 1'b0;
        clr_sticky      = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        sticky_m = 1'b0;
        cnt_m    = 0;
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        logic [width-1:0] y0;
        y0 = width'($urandom_range(1, 15));
        rst_n           = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_y        = y0;
        bus.in_sel      = OP_XOR;
        bus.in_carry    = 1'b0;
        bus.in_overflow = 1'b0;
        bus.out_ready   = 1'b1;
        clr_sticky      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (result_cnt !== '0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", result_cnt); end
        checks++; if (sticky_ovf !== 1'b0) begin failures++; $display("FAIL reset_sticky: got %b expected 0", sticky_ovf); end
        checks++; if (bus.out_y !== '0) begin failures++; $display("FAIL reset_out_y: got %h expected 0", bus.out_y); end
        exp_q.delete();
        sticky_m = 1'b0;
        cnt_m    = 0;
        rst_n    = 1'b1;
        drive_cycle(1'b1, y0, OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_y !== y0) begin failures++; $display("FAIL reset_first_word: got valid=%b y=%h expected valid=1 y=%h", bus.out_valid, bus.out_y, y0); end
        drive_cycle(1'b0, '0, OP_XOR, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || result_cnt !== 2'd1) begin failures++; $display("FAIL reset_drain: got valid=%b cnt=%0d expected valid=0 cnt=1", bus.out_valid, result_cnt); end
    endtask

    task automatic test_streaming();
        do_reset();
        drive_cycle(1'b1, 4'b1000, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_y !== 4'b1000) begin failures++; $display("FAIL stream_w1: got valid=%b y=%h expected valid=1 y=8", bus.out_valid, bus.out_y); end
        checks++; if (bus.out_neg !== 1'b1 || bus.out_overflow !== 1'b1 || bus.out_carry !== 1'b0) begin failures++; $display("FAIL stream_w1_flags: got neg=%b ovf=%b carry=%b expected 1 1 0", bus.out_neg, bus.out_overflow, bus.out_carry); end
        checks++; if (sticky_ovf !== 1'b1) begin failures++; $display("FAIL stream_sticky1: got %b expected 1", sticky_ovf); end
        drive_cycle(1'b1, 4'b1111, OP_SUB, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_y !== 4'b1111 || bus.out_carry !== 1'b1 || bus.out_overflow !== 1'b0) begin failures++; $display("FAIL stream_w2: got valid=%b y=%h carry=%b ovf=%b expected 1 f 1 0", bus.out_valid, bus.out_y, bus.out_carry, bus.out_overflow); end
        drive_cycle(1'b0, '0, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (result_cnt !== 2'd2 || sticky_ovf !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_end: got cnt=%0d sticky=%b valid=%b expected 2 1 0", result_cnt, sticky_ovf, bus.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [width-1:0] w1;
        logic [width-1:0] w2;
        logic [width-1:0] w3;
        do_reset();
        w1 = width'($urandom);
        w2 = width'($urandom);
        w3 = width'($urandom);
        drive_cycle(1'b1, w1, OP_OR, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b1 || bus.out_y !== w1) begin failures++; $display("FAIL bp_w1: got rdy=%b y=%h expected rdy=1 y=%h", bus.in_ready, bus.out_y, w1); end
        drive_cycle(1'b1, w2, OP_OR, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b0 || bus.out_y !== w1) begin failures++; $display("FAIL bp_full: got rdy=%b y=%h expected rdy=0 y=%h", bus.in_ready, bus.out_y, w1); end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, w3, OP_OR, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++; if (bus.in_ready !== 1'b0 || bus.out_y !== w1 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold: got rdy=%b valid=%b y=%h expected rdy=0 valid=1 y=%h", bus.in_ready, bus.out_valid, bus.out_y, w1); end
        end
        drive_cycle(1'b1, w3, OP_OR, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.out_y !== w2 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_drain1: got y=%h rdy=%b expected y=%h rdy=1", bus.out_y, bus.in_ready, w2); end
        drive_cycle(1'b1, w3, OP_OR, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.out_y !== w3 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_drain2: got y=%h valid=%b expected y=%h valid=1", bus.out_y, bus.out_valid, w3); end
        drive_cycle(1'b0, '0, OP_OR, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || result_cnt !== 2'd3) begin failures++; $display("FAIL bp_end: got valid=%b cnt=%0d expected 0 3", bus.out_valid, result_cnt); end
    endtask

    task automatic test_masking();
        do_reset();
        drive_cycle(1'b1, width'($urandom), OP_AND, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.out_carry !== 1'b0 || bus.out_overflow !== 1'b0 || sticky_ovf !== 1'b0) begin failures++; $display("FAIL mask_and: got carry=%b ovf=%b sticky=%b expected 0 0 0", bus.out_carry, bus.out_overflow, sticky_ovf); end
        drive_cycle(1'b1, 4'b0000, OP_XOR, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.out_zero !== 1'b1 || bus.out_y !== 4'b0000 || bus.out_neg !== 1'b0) begin failures++; $display("FAIL mask_xor_zero: got zero=%b y=%h neg=%b expected 1 0 0", bus.out_zero, bus.out_y, bus.out_neg); end
        drive_cycle(1'b1, 4'b0000, 4'b1100, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.out_zero !== 1'b1 || bus.out_carry !== 1'b0 || bus.out_overflow !== 1'b0 || sticky_ovf !== 1'b0) begin failures++; $display("FAIL mask_illegal: got zero=%b carry=%b ovf=%b sticky=%b expected 1 0 0 0", bus.out_zero, bus.out_carry, bus.out_overflow, sticky_ovf); end
    endtask

    task automatic test_sticky();
        do_reset();
        drive_cycle(1'b1, 4'b1000, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (sticky_ovf !== 1'b1) begin failures++; $display("FAIL sticky_set_wins: got %b expected 1", sticky_ovf); end
        drive_cycle(1'b0, '0, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (sticky_ovf !== 1'b0) begin failures++; $display("FAIL sticky_clear: got %b expected 0", sticky_ovf); end
    endtask

    task automatic test_counter_wrap();
        int exp_cnt[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive_cycle(k < 5, width'($urandom), OP_XOR, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++; if (result_cnt !== exp_cnt[k][cnt_w-1:0]) begin failures++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", k, result_cnt, exp_cnt[k]); end
        end
        drive_cycle(1'b1, width'($urandom), OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, width'($urandom), OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL wrap_full: got rdy=%b expected 0", bus.in_ready); end
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        sticky_m = 1'b0;
        cnt_m    = 0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || result_cnt !== '0 || bus.out_y !== '0) begin failures++; $display("FAIL full_reset: got valid=%b rdy=%b cnt=%0d y=%h expected 0 1 0 0", bus.out_valid, bus.in_ready, result_cnt, bus.out_y); end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, '0, OP_XOR, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++; if (bus.out_valid !== 1'b0 || result_cnt !== '0) begin failures++; $display("FAIL no_stale[%0d]: got valid=%b cnt=%0d expected 0 0", k, bus.out_valid, result_cnt); end
        end
    endtask

    task automatic test_random();
        logic             v;
        logic             ordy;
        logic             clr;
        logic [3:0]       sel;
        logic [width-1:0] y;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            clr  = ($urandom_range(0, 9) == 0);
            sel  = 4'($urandom_range(0, 15));
            y    = (sel >= 4'd11) ? '0 : width'($urandom);
            drive_cycle(v, y, sel, 1'($urandom), 1'($urandom), ordy, clr);
            checks++; if (bus.in_ready !== (exp_q.size() < 2)) begin failures++; $display("FAIL rnd_in_ready@%0d: got %b expected %b", i, bus.in_ready, exp_q.size() < 2); end
            checks++; if (bus.out_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL rnd_out_valid@%0d: got %b expected %b", i, bus.out_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                checks++;
                if (bus.out_y !== exp_q[0].y || bus.out_carry !== exp_q[0].c || bus.out_overflow !== exp_q[0].o ||
                    bus.out_zero !== exp_q[0].z || bus.out_neg !== exp_q[0].n) begin
                    failures++;
                    $display("FAIL rnd_word@%0d: got y=%h c=%b o=%b z=%b n=%b expected y=%h c=%b o=%b z=%b n=%b", i,
                             bus.out_y, bus.out_carry, bus.out_overflow, bus.out_zero, bus.out_neg,
                             exp_q[0].y, exp_q[0].c, exp_q[0].o, exp_q[0].z, exp_q[0].n);
                end
`ifdef ALU_RESULT_PARITY_EN
                checks++; if (bus.out_parity !== exp_q[0].p) begin failures++; $display("FAIL rnd_parity@%0d: got %b expected %b", i, bus.out_parity, exp_q[0].p); end
`endif
            end
            checks++; if (sticky_ovf !== sticky_m) begin failures++; $display("FAIL rnd_sticky@%0d: got %b expected %b", i, sticky_ovf, sticky_m); end
            checks++; if (result_cnt !== cnt_m[cnt_w-1:0]) begin failures++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", i, result_cnt, cnt_m); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_masking();
        test_sticky();
        test_counter_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
